// File: rtl/router_pkg.sv
// router_pkg: shared router constants, scheduler state encoding and round-robin pick
package router_pkg;
    localparam int N_PORTS = 8;
    localparam int WORD_W = 32;
    localparam int PTR_W = $clog2(N_PORTS);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
    // Scanning from the top down lets the request closest to p (upward, wrapping) win.
    function automatic logic [N_PORTS-1:0] rr_pick(input logic [N_PORTS-1:0] r, input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] i;
        rr_pick = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            i = p + PTR_W'(k);
            if (r[i]) rr_pick = N_PORTS'(1) << i;
        end
    endfunction
endpackage

// File: rtl/outport_scheduler_if.sv
// outport_scheduler_if: FIFO-side request/dequeue and serializer-side word handshake
interface outport_scheduler_if import router_pkg::*; ();
    logic [N_PORTS-1:0] req;
    logic [N_PORTS*WORD_W-1:0] req_data;
    logic [N_PORTS-1:0] deq;
    logic [WORD_W-1:0] out_data;
    logic out_vld;
    logic port_busy;
    modport master (input req, req_data, port_busy, output deq, out_data, out_vld);
    modport slave (output req, req_data, port_busy, input deq, out_data, out_vld);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick returning one-hot grant and its index
module rr_arbiter import router_pkg::*; (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);
    always_comb begin
        gnt = rr_pick(req, ptr);
        idx = '0;
        for (int k = 0; k < N_PORTS; k++) if (gnt[k]) idx = PTR_W'(k);
    end
endmodule

// File: rtl/outport_scheduler.sv
// outport_scheduler: round-robin owner of one output port, holding it until the serializer finishes
module outport_scheduler import router_pkg::*; #(
    parameter int TMO = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    outport_scheduler_if.master     bus,
    output logic [N_PORTS-1:0]      grant,
    output logic [15:0]             sent_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    err_tmo
);
    localparam int TW = $clog2(TMO + 1);
    state_t state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
    logic [N_PORTS-1:0] grant_q, grant_d, win;
    logic [WORD_W-1:0] data_q, data_d;
    logic [15:0] sent_q, sent_d, drop_q, drop_d;
    logic err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    rr_arbiter u_arb (.req(bus.req), .ptr(ptr_q), .gnt(win), .idx(win_idx));
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        grant_d = grant_q;
        data_d = data_q;
        sent_d = sent_q;
        drop_d = drop_q;
        err_d = err_q;
        tmo_d = tmo_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                grant_d = win;
                idx_d = win_idx;
                data_d = bus.req_data[win_idx*WORD_W +: WORD_W];
                state_d = ISSUE;
            end
            // The serializer ignores zero words, so they are popped and counted but never issued.
            ISSUE: if (data_q != '0) begin
                tmo_d = '0;
                state_d = WAIT_START;
            end else begin
                drop_d = drop_q + 16'd1;
                ptr_d = idx_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
            WAIT_START: if (bus.port_busy) state_d = WAIT_DONE;
            else begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d == TW'(TMO)) begin
                    err_d = 1'b1;
                    ptr_d = idx_q + 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: if (!bus.port_busy) begin
                sent_d = sent_q + 16'd1;
                ptr_d = idx_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            idx_q <= '0;
            grant_q <= '0;
            data_q <= '0;
            sent_q <= '0;
            drop_q <= '0;
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            grant_q <= grant_d;
            data_q <= data_d;
            sent_q <= sent_d;
            drop_q <= drop_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end
    assign bus.deq = (state_q == ISSUE) ? grant_q : '0;
    assign bus.out_vld = (state_q == ISSUE) && (data_q != '0);
    assign bus.out_data = data_q;
    assign grant = grant_q;
    assign sent_cnt = sent_q;
    assign drop_cnt = drop_q;
    assign err_tmo = err_q;
endmodule

// File: tb/tb_outport_scheduler.sv
// tb_outport_scheduler: directed stimulus with a queued scoreboard checked by an output monitor
module tb_outport_scheduler;
    import router_pkg::*;
    typedef struct packed {
        logic [7:0]  deq;
        logic        vld;
        logic [31:0] data;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] grant;
    logic [15:0] sent_cnt, drop_cnt;
    logic err_tmo;
    exp_t exp_q[$];
    exp_t e;
    int pass_n = 0;
    int total_n = 0;
    bit ser_en = 1'b1;
    int ser_len = 3;
    logic [7:0] prev_deq = '0;
    always #5 clock = ~clock;
    outport_scheduler_if bus();
    outport_scheduler #(.TMO(8)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .grant(grant), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .err_tmo(err_tmo)
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %h, required %h", n, act, req);
    endtask
    task automatic push(input logic [7:0] d, input logic v, input logic [31:0] w);
        exp_q.push_back('{d, v, w});
    endtask
    task automatic wait_sent(input logic [15:0] t, input int budget);
        int n = 0;
        while (sent_cnt !== t && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("sent_cnt_wait", sent_cnt, t);
    endtask
    // Monitor: every dequeue pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (!reset && (bus.deq != '0 || bus.out_vld)) begin
            if (bus.deq != '0) chk("deq_spacing", prev_deq, 0);
            if (exp_q.size() == 0) begin
                total_n++;
                $display("FAIL unexpected_issue: got deq %h vld %b with nothing expected", bus.deq, bus.out_vld);
            end else begin
                e = exp_q.pop_front();
                chk("deq", bus.deq, e.deq);
                chk("out_vld", bus.out_vld, e.vld);
                chk("out_data", bus.out_data, e.data);
            end
        end
        prev_deq = bus.deq;
    end
    // Serializer model: busy from the cycle after out_vld for ser_len cycles.
    initial forever begin
        @(negedge clock);
        if (ser_en && bus.out_vld) begin
            @(posedge clock);
            #1 bus.port_busy = 1'b1;
            repeat (ser_len) @(posedge clock);
            #1 bus.port_busy = 1'b0;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.req = '0;
        bus.req_data = '0;
        bus.port_busy = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", grant, 0);
        chk("rst_deq", bus.deq, 0);
        chk("rst_vld", bus.out_vld, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err_tmo, 0);
        // Single word from port 0 with a long serializer run.
        ser_len = 32;
        bus.req_data[0*32 +: 32] = 32'hDEADBEEF;
        push(8'h01, 1'b1, 32'hDEADBEEF);
        @(posedge clock);
        #1 reset = 1'b0;
        bus.req = 8'h01;
        @(posedge clock);
        #1 bus.req = '0;
        chk("t1_grant", grant, 32'h01);
        wait_sent(16'd1, 100);
        chk("t1_grant_idle", grant, 0);
        chk("t1_ptr", dut.ptr_q, 1);
        // All ports requesting: rotation starts at ptr=1.
        ser_len = 3;
        for (int i = 0; i < 8; i++) bus.req_data[i*32 +: 32] = 32'h1000_0000 + i;
        for (int k = 0; k < 9; k++) push(8'h01 << ((1 + k) % 8), 1'b1, 32'h1000_0000 + ((1 + k) % 8));
        bus.req = 8'hFF;
        wait_sent(16'd10, 200);
        bus.req = '0;
        // Zero word from port 2 is dropped.
        bus.req_data[2*32 +: 32] = '0;
        push(8'h04, 1'b0, 32'h0);
        bus.req = 8'h04;
        @(posedge clock);
        #1 bus.req = '0;
        @(posedge clock);
        @(negedge clock);
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_grant", grant, 0);
        chk("drop_state", dut.state_q, IDLE);
        chk("drop_sent", sent_cnt, 10);
        // Serializer never starts: timeout.
        ser_en = 1'b0;
        bus.req_data[3*32 +: 32] = 32'h12345678;
        push(8'h08, 1'b1, 32'h12345678);
        bus.req = 8'h08;
        @(posedge clock);
        #1 bus.req = '0;
        @(posedge clock);
        repeat (7) @(posedge clock);
        @(negedge clock);
        chk("tmo_early", err_tmo, 0);
        @(posedge clock);
        @(negedge clock);
        chk("tmo_err", err_tmo, 1);
        chk("tmo_grant", grant, 0);
        chk("tmo_state", dut.state_q, IDLE);
        chk("tmo_sent", sent_cnt, 10);
        ser_en = 1'b1;
        bus.req_data[5*32 +: 32] = 32'h55AA55AA;
        push(8'h20, 1'b1, 32'h55AA55AA);
        bus.req = 8'h20;
        @(posedge clock);
        #1 bus.req = '0;
        wait_sent(16'd11, 100);
        chk("tmo_sticky", err_tmo, 1);
        // Reset in WAIT_DONE while port 7 owns the port.
        ser_en = 1'b0;
        bus.req_data[7*32 +: 32] = 32'h77777777;
        push(8'h80, 1'b1, 32'h77777777);
        bus.req = 8'h80;
        @(posedge clock);
        @(posedge clock);
        #1 bus.port_busy = 1'b1;
        repeat (3) @(posedge clock);
        #1 chk("mid_state", dut.state_q, WAIT_DONE);
        chk("mid_grant", grant, 32'h80);
        reset = 1'b1;
        bus.req = 8'h81;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_deq", bus.deq, 0);
        chk("mid_rst_vld", bus.out_vld, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_sent", sent_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_err", err_tmo, 0);
        chk("mid_rst_state", dut.state_q, IDLE);
        bus.port_busy = 1'b0;
        ser_en = 1'b1;
        push(8'h01, 1'b1, 32'h1000_0000);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 bus.req = '0;
        chk("post_rst_grant", grant, 32'h01);
        wait_sent(16'd1, 100);
        // Counter wrap FFFF -> 0000.
        @(negedge clock);
        force dut.sent_q = 16'hFFFF;
        @(posedge clock);
        #1 release dut.sent_q;
        chk("wrap_preload", sent_cnt, 32'hFFFF);
        bus.req_data[1*32 +: 32] = 32'hABCD0123;
        push(8'h02, 1'b1, 32'hABCD0123);
        bus.req = 8'h02;
        @(posedge clock);
        #1 bus.req = '0;
        wait_sent(16'd0, 100);
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
